// File: rtl/mat_mult_pkg.sv
// Shared types and index helpers for the matrix multiplier.
package mat_mult_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Wide enough that a full N-term sum of W x W products never overflows.
   function automatic int acc_width(input int n, input int w);
      return 2 * w + $clog2(n);
   endfunction

   function automatic int elem_lsb(input int n, input int w,
                                   input int r, input int c);
      return w * (n * n - 1 - (r * n + c));
   endfunction

endpackage

// File: rtl/mat_mult_mac.sv
// Signed multiply-accumulate with range reduction to W bits.
// MAT_MULT_SAT_EN selects saturation; otherwise out-of-range values wrap.
module mat_mult_mac
   import mat_mult_pkg::*;
#(
   parameter int W    = 32,
   parameter int ACCW = 65
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] elem,
   output logic                range_err
);

   logic signed [2*W-1:0]  prod;
   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] base;
   logic signed [ACCW-1:0] prod_x;
   logic signed [ACCW-1:0] sum;
   logic [ACCW-W:0]        top;

   assign prod   = a * b;
   assign prod_x = {{(ACCW-2*W){prod[2*W-1]}}, prod};
   assign base   = clr ? '0 : acc;
   assign sum    = base + prod_x;

   // The sum fits in W bits exactly when all bits from W-1 upward agree.
   assign top       = sum[ACCW-1:W-1];
   assign range_err = !((&top) || !(|top));

`ifdef MAT_MULT_SAT_EN
   assign elem = !range_err ? sum[W-1:0] :
                 sum[ACCW-1] ? {1'b1, {(W-1){1'b0}}} :
                               {1'b0, {(W-1){1'b1}}};
`else
   assign elem = sum[W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/mat_mult_param.sv
// N x N signed matrix multiplier, one MAC per cycle, i/j/k loop order.
// Build with MAT_MULT_SAT_EN to saturate out-of-range elements.
module mat_mult_param
   import mat_mult_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N*N*W-1:0] A,
   input  logic [N*N*W-1:0] B,
   output logic [N*N*W-1:0] Res,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam int ACCW = acc_width(N, W);
   localparam int CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state;
   logic [N*N*W-1:0] a_reg;
   logic [N*N*W-1:0] b_reg;
   logic [N*N*W-1:0] res_buf;
   logic [CW-1:0]    i;
   logic [CW-1:0]    j;
   logic [CW-1:0]    k;
   logic             ovf_acc;
   logic signed [W-1:0] a_op;
   logic signed [W-1:0] b_op;
   logic signed [W-1:0] elem;
   logic             range_err;
   logic             mac_en;
   logic             k_last;

   assign a_op   = a_reg[elem_lsb(N, W, int'(i), int'(k)) +: W];
   assign b_op   = b_reg[elem_lsb(N, W, int'(k), int'(j)) +: W];
   assign busy   = (state != S_IDLE);
   assign mac_en = (state == S_MAC);
   assign k_last = (k == LAST);

   mat_mult_mac #(
      .W    (W),
      .ACCW (ACCW)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .en        (mac_en),
      .clr       (k == '0),
      .a         (a_op),
      .b         (b_op),
      .elem      (elem),
      .range_err (range_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         res_buf <= '0;
         Res     <= '0;
         i       <= '0;
         j       <= '0;
         k       <= '0;
         ovf_acc <= 1'b0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg   <= A;
                  b_reg   <= B;
                  i       <= '0;
                  j       <= '0;
                  k       <= '0;
                  ovf_acc <= 1'b0;
                  state   <= S_MAC;
               end
            end
            S_MAC: begin
               if (k_last) begin
                  res_buf[elem_lsb(N, W, int'(i), int'(j)) +: W] <= elem;
                  ovf_acc <= ovf_acc | range_err;
                  k <= '0;
                  if (j == LAST) begin
                     j <= '0;
                     if (i == LAST) begin
                        i     <= '0;
                        state <= S_DONE;
                     end else begin
                        i <= i + 1'b1;
                     end
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            // Result and flag are published together as one snapshot.
            S_DONE: begin
               Res   <= res_buf;
               ovf   <= ovf_acc;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mult_param.sv
// Bench for mat_mult_param: three configurations, directed table and random jobs.
module tb_mat_mult_param;

   typedef logic [8:0][31:0] arr_t;
   typedef struct packed {
      logic [1:0] s;
      arr_t       a;
      arr_t       b;
      arr_t       r;
      logic       ov;
   } vec_t;

`ifdef MAT_MULT_SAT_EN
   localparam int R30 = 127;
   localparam int R31 = -128;
`else
   localparam int R30 = 2;
   localparam int R31 = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic start0, start1, start2;
   logic [127:0] a0, b0, r0;
   logic [31:0]  a1, b1, r1;
   logic [143:0] a2, b2, r2;
   logic busy0, done0, ovf0;
   logic busy1, done1, ovf1;
   logic busy2, done2, ovf2;

   int vecs = 0;
   int bad  = 0;

   mat_mult_param #(.N(2), .W(32)) u0 (
      .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0),
      .Res(r0), .busy(busy0), .done(done0), .ovf(ovf0));
   mat_mult_param #(.N(2), .W(8)) u1 (
      .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
      .Res(r1), .busy(busy1), .done(done1), .ovf(ovf1));
   mat_mult_param #(.N(3), .W(16)) u2 (
      .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
      .Res(r2), .busy(busy2), .done(done2), .ovf(ovf2));

   function automatic int nof(input int s);
      return (s == 2) ? 3 : 2;
   endfunction

   function automatic int wof(input int s);
      return (s == 0) ? 32 : ((s == 1) ? 8 : 16);
   endfunction

   task automatic check(input string name, input logic [287:0] act,
                        input logic [287:0] exp);
      vecs++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ab(input int s, input logic [287:0] a,
                         input logic [287:0] b);
      case (s)
         0: begin a0 = a[127:0]; b0 = b[127:0]; end
         1: begin a1 = a[31:0];  b1 = b[31:0];  end
         default: begin a2 = a[143:0]; b2 = b[143:0]; end
      endcase
   endtask

   task automatic set_start(input int s, input logic v);
      case (s)
         0: start0 = v;
         1: start1 = v;
         default: start2 = v;
      endcase
   endtask

   function automatic logic [287:0] get_res(input int s);
      case (s)
         0: return {160'b0, r0};
         1: return {256'b0, r1};
         default: return {144'b0, r2};
      endcase
   endfunction

   function automatic logic get_done(input int s);
      case (s)
         0: return done0;
         1: return done1;
         default: return done2;
      endcase
   endfunction

   function automatic logic get_ovf(input int s);
      case (s)
         0: return ovf0;
         1: return ovf1;
         default: return ovf2;
      endcase
   endfunction

   function automatic logic get_busy(input int s);
      case (s)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic arr_t arr(input int x0, input int x1, input int x2,
                                input int x3, input int x4 = 0,
                                input int x5 = 0, input int x6 = 0,
                                input int x7 = 0, input int x8 = 0);
      arr_t v;
      v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3; v[4] = x4;
      v[5] = x5; v[6] = x6; v[7] = x7; v[8] = x8;
      return v;
   endfunction

   task automatic to_l(input arr_t v, output longint o[9]);
      for (int e = 0; e < 9; e++) o[e] = longint'($signed(v[e]));
   endtask

   // Row-major element list -> packed bus with element (0,0) in the MSBs.
   function automatic logic [287:0] pack(input int s, input longint v[9]);
      logic [287:0] x;
      int n, w;
      n = nof(s);
      w = wof(s);
      x = '0;
      for (int e = 0; e < n * n; e++)
         for (int bt = 0; bt < w; bt++)
            x[w * (n * n - 1 - e) + bt] = v[e][bt];
      return x;
   endfunction

   // Plain integer product, then fit each element into W bits.
   task automatic model(input int s, input longint a[9], input longint b[9],
                        output longint r[9], output bit ov);
      int n, w;
      longint lo, hi, acc, m;
      n = nof(s);
      w = wof(s);
      lo = -(64'sd1 <<< (w - 1));
      hi = -lo - 1;
      ov = 1'b0;
      for (int e = 0; e < 9; e++) r[e] = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            acc = 0;
            for (int k = 0; k < n; k++) acc += a[i * n + k] * b[k * n + j];
            if (acc < lo || acc > hi) begin
               ov = 1'b1;
`ifdef MAT_MULT_SAT_EN
               r[i * n + j] = (acc < lo) ? lo : hi;
`else
               m = acc & ((64'sd1 <<< w) - 1);
               if (m > hi) m -= (64'sd1 <<< w);
               r[i * n + j] = m;
`endif
            end else begin
               r[i * n + j] = acc;
            end
         end
   endtask

   task automatic do_job(input int s, input longint a[9], input longint b[9],
                         output logic [287:0] res, output bit ov,
                         output int cyc);
      @(negedge clk);
      set_ab(s, pack(s, a), pack(s, b));
      set_start(s, 1'b1);
      @(posedge clk);
      #1;
      set_start(s, 1'b0);
      set_ab(s, {9{$urandom}}, {9{$urandom}});
      cyc = 0;
      while (!get_done(s) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      res = get_res(s);
      ov  = get_ovf(s);
   endtask

   task automatic run_check(input int s, input longint a[9],
                            input longint b[9], input logic [287:0] exp_r,
                            input bit exp_ov, input string tag);
      logic [287:0] res;
      bit ov;
      int cyc, n;
      n = nof(s);
      do_job(s, a, b, res, ov, cyc);
      check({tag, "_latency"}, 288'(cyc), 288'(n * n * n + 1));
      check({tag, "_res"}, res, exp_r);
      check({tag, "_ovf"}, 288'(ov), 288'(exp_ov));
      @(posedge clk);
      #1;
      check({tag, "_done_width"}, 288'(get_done(s)), 288'(0));
      check({tag, "_res_hold"}, get_res(s), exp_r);
   endtask

   vec_t   tbl[4];
   longint la[9], lb[9], lr[9], la2[9], lb2[9], lr2[9];
   bit     ov2, mov;
   int     nd, first, second, s;
   logic [287:0] res1, res2;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{s: 2'd0, a: arr(-1, 2, 3, 4), b: arr(1, 2, 3, 5),
                 r: arr(5, 8, 15, 26), ov: 1'b0};
      tbl[1] = '{s: 2'd1, a: arr(127, 127, 127, 127),
                 b: arr(127, 127, 127, 127),
                 r: arr(R30, R30, R30, R30), ov: 1'b1};
      tbl[2] = '{s: 2'd1, a: arr(-128, -128, -128, -128),
                 b: arr(127, 127, 127, 127),
                 r: arr(R31, R31, R31, R31), ov: 1'b1};
      tbl[3] = '{s: 2'd2, a: arr(1, 0, 0, 0, 1, 0, 0, 0, 1),
                 b: arr(1, 2, 3, 4, 5, 6, 7, 8, 9),
                 r: arr(1, 2, 3, 4, 5, 6, 7, 8, 9), ov: 1'b0};

      rst = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int q = 0; q < 3; q++) begin
         check($sformatf("reset_busy%0d", q), 288'(get_busy(q)), 288'(0));
         check($sformatf("reset_done%0d", q), 288'(get_done(q)), 288'(0));
         check($sformatf("reset_ovf%0d", q), 288'(get_ovf(q)), 288'(0));
         check($sformatf("reset_res%0d", q), get_res(q), 288'(0));
      end
      @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 4; t++) begin
         to_l(tbl[t].a, la);
         to_l(tbl[t].b, lb);
         to_l(tbl[t].r, lr);
         run_check(int'(tbl[t].s), la, lb, pack(int'(tbl[t].s), lr),
                   tbl[t].ov, $sformatf("table%0d", t));
      end

      for (int it = 0; it < 24; it++) begin
         s = it % 3;
         for (int e = 0; e < 9; e++) begin
            if (s == 0) begin
               la[e] = longint'($urandom_range(0, 2097152)) - 1048576;
               lb[e] = longint'($urandom_range(0, 2097152)) - 1048576;
            end else if (s == 1) begin
               la[e] = longint'($urandom_range(0, 255)) - 128;
               lb[e] = longint'($urandom_range(0, 255)) - 128;
            end else begin
               la[e] = longint'($urandom_range(0, 65535)) - 32768;
               lb[e] = longint'($urandom_range(0, 65535)) - 32768;
            end
         end
         model(s, la, lb, lr, mov);
         run_check(s, la, lb, pack(s, lr), mov, $sformatf("rand%0d", it));
      end

      // Start re-pulsed mid-MAC and in DONE, then accepted in the next idle cycle.
      to_l(tbl[0].a, la);
      to_l(tbl[0].b, lb);
      to_l(tbl[0].r, lr);
      to_l(arr(2, 0, 0, 2), la2);
      to_l(arr(1, 2, 3, 4), lb2);
      model(0, la2, lb2, lr2, ov2);
      @(negedge clk);
      set_ab(0, pack(0, la), pack(0, lb));
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      nd = 0; first = 0; second = 0;
      res1 = '0; res2 = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 3 || c == 9 || c == 10) begin
            set_ab(0, pack(0, la2), pack(0, lb2));
            start0 = 1'b1;
         end
         @(posedge clk);
         #1;
         start0 = 1'b0;
         if (c == 10) check("rearm_busy", 288'(busy0), 288'(1));
         if (done0) begin
            nd++;
            if (nd == 1) begin first = c; res1 = r0; end
            else if (nd == 2) begin second = c; res2 = r0; end
         end
      end
      check("ignore_first_cycle", 288'(first), 288'(9));
      check("ignore_first_res", res1, pack(0, lr));
      check("rearm_done_cycle", 288'(second), 288'(19));
      check("rearm_res", res2, pack(0, lr2));
      check("ignore_done_count", 288'(nd), 288'(2));

      // Reset in the middle of a job on a unit holding a nonzero, overflowed result.
      to_l(tbl[1].a, la);
      to_l(tbl[1].b, lb);
      to_l(tbl[1].r, lr);
      run_check(1, la, lb, pack(1, lr), 1'b1, "pre_reset");
      @(negedge clk);
      set_ab(1, pack(1, la), pack(1, lb));
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midreset_busy", 288'(busy1), 288'(0));
      check("midreset_res", 288'(r1), 288'(0));
      check("midreset_ovf", 288'(ovf1), 288'(0));
      check("midreset_done", 288'(done1), 288'(0));
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done1) nd++;
      end
      check("midreset_no_done", 288'(nd), 288'(0));
      run_check(1, la, lb, pack(1, lr), 1'b1, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

endmodule

// File: doc/mat_mult_param.md
MAT_MULT_PARAM -- requirements
Module: mat_mult_param

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension (N x N), legal range 2..8.
REQ-002 SHALL have parameter W, default 32, meaning signed element width in bits, legal range 4..32.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  meaning request one multiply job; sampled only in IDLE.
REQ-006 SHALL have port A  input  N*N*W  meaning packed signed matrix A; element (r,c) at bits [W*(N*N-1-(r*N+c)) +: W], so (0,0) is in the MSBs.
REQ-007 SHALL have port B  input  N*N*W  meaning packed signed matrix B, same packing as A.
REQ-008 SHALL have port Res  output  N*N*W  meaning packed signed product A*B, same packing.
REQ-009 SHALL have port busy  output  1  meaning a job is in progress (any state other than IDLE).
REQ-010 SHALL have port done  output  1  meaning a one-cycle pulse marking that Res holds a new result.
REQ-011 SHALL have port ovf  output  1  meaning at least one element of the last result did not fit in W bits.

Function
REQ-012 SHALL implement states IDLE, MAC, DONE; IDLE->MAC on start=1; MAC->DONE after the final MAC; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL latch A and B into internal registers on the edge that accepts start; later changes to A and B SHALL NOT affect the job.
REQ-014 SHALL perform exactly one signed multiply-accumulate per MAC cycle, with loop order i (row) outer, j (column), k (inner) innermost: acc += A[i][k]*B[k][j].
REQ-015 SHALL use an accumulator of ACCW = 2*W + clog2(N) bits, so that no intermediate value overflows.
REQ-016 SHALL clear acc at k==0 and, at k==N-1, store the reduced element (i,j) in an internal result buffer.
REQ-017 SHALL spend exactly N^3 cycles in MAC.
REQ-018 SHALL assert done for exactly one cycle, N^3+1 cycles after the start-accept edge (9 cycles for N=2).
REQ-019 SHALL update Res atomically in the cycle done asserts, and SHALL hold Res unchanged until the next done.
REQ-020 SHALL update ovf together with Res: ovf=1 if any element's accumulator fell outside [-2^(W-1), 2^(W-1)-1], else 0.
REQ-021 SHALL ignore start while busy=1, including during DONE; no queuing of requests.
REQ-022 SHALL accept start in the cycle immediately after DONE (back-to-back jobs with one IDLE cycle).

Reset
REQ-023 SHALL, on rst=1 at any time (including mid-job), immediately enter IDLE and clear busy, done, ovf, Res, acc, counters and latched operands to 0.
REQ-024 SHALL discard any partial job on reset, and SHALL NOT assert done for it.

Configuration
REQ-025 SHALL, when MAT_MULT_SAT_EN is defined, clamp out-of-range elements to 2^(W-1)-1 or -2^(W-1).
REQ-026 SHALL, when MAT_MULT_SAT_EN is undefined, keep the low W bits of out-of-range elements (two's-complement wrap); ovf behaviour is identical in both builds.

Structure
REQ-027 SHALL place the state enum typedef, the ACCW computation function and the packed-element index function in shared package mat_mult_pkg.
REQ-028 SHALL place the multiply, accumulate and range-reduce (saturate or wrap) datapath in one sub-module, mat_mult_mac; the FSM and counters stay in mat_mult_param.

Verification
REQ-029 SHALL cover: N=2, W=32, A={-1,2,3,4}, B={1,2,3,5}, start pulse -> done 9 cycles later, Res={5,8,15,26}, ovf=0.
REQ-030 SHALL cover: N=2, W=8, A and B all 127 -> ovf=1; Res all 127 with MAT_MULT_SAT_EN, all 2 without it.
REQ-031 SHALL cover: N=2, W=8, A all -128, B all 127 -> ovf=1; Res all -128 with MAT_MULT_SAT_EN, all 0 without it.
REQ-032 SHALL cover: N=3, W=16, A=identity, B={1..9} -> done after 28 cycles, Res={1..9}; A changed during MAC with no effect on the result.
REQ-033 SHALL cover: start re-pulsed at MAC cycle 3 and during DONE -> ignored, exactly one done; a new start in the next IDLE cycle is accepted.
REQ-034 SHALL cover: rst asserted at MAC cycle 5 -> busy=0, Res=0, ovf=0 immediately, and no done pulse follows.
